// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch-side control logic.
package pipe_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_BYTES  = 4;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } pc_state_e;

endpackage

// File: rtl/redirect_arbiter.sv
// Combinational priority select of fetch redirects: trap, then aligned branch,
// then misaligned branch (rerouted to the trap vector). Zero latency, no backpressure.
module redirect_arbiter
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            redir,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] trap_base;

  // mtvec low bits are mode bits, never part of the handler address
  assign trap_base = trap_vector & ~XLEN'(INSTR_BYTES - 1);

  always_comb begin
    redir    = trap | br_taken;
    target   = trap_base;
    misalign = 1'b0;
    if (!trap && br_taken) begin
      if (br_target[1:0] == 2'b00) begin
        target = br_target;
      end else begin
        misalign = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: combinational pc_next_o, owns imem request and IF/ID, ID/EX flushes.
// Zero-cycle decision; imem stalls hold the PC in WAIT, stale words after a redirect are dropped in DISCARD.
module pc_sequencer
  import pipe_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BOOT_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_cur_i,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            imem_ready_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            imem_req_o,
  output logic            if_valid_o,
  output logic            if_id_flush_o,
  output logic            id_ex_flush_o,
  output logic            misalign_o,
  output logic [1:0]      state_o
);

  pc_state_e       state;
  pc_state_e       state_nxt;
  logic [3:0]      boot_cnt;
  logic            redir;
  logic [XLEN-1:0] redir_target;
  logic            redir_misalign;

  redirect_arbiter #(
    .XLEN(XLEN)
  ) u_redirect_arbiter (
    .trap        (trap_i),
    .trap_vector (trap_vector_i),
    .br_taken    (br_taken_i),
    .br_target   (br_target_i),
    .redir       (redir),
    .target      (redir_target),
    .misalign    (redir_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      boot_cnt <= 4'(BOOT_CYCLES);
    end else begin
      state <= state_nxt;
      if (state == BOOT && boot_cnt != 4'd0) begin
        boot_cnt <= boot_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_next_o     = pc_cur_i;
    imem_req_o    = 1'b0;
    if_valid_o    = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    misalign_o    = 1'b0;

    unique case (state)
      BOOT: begin
        pc_next_o     = RESET_VECTOR;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
        if (boot_cnt <= 4'd1) begin
          state_nxt = FETCH;
        end
      end

      FETCH, WAIT: begin
        imem_req_o = 1'b1;
        if (redir) begin
          pc_next_o     = redir_target;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          misalign_o    = redir_misalign;
          // an unanswered request would otherwise return a wrong-path word
          state_nxt     = (state == WAIT || !imem_ready_i) ? DISCARD : FETCH;
        end else if (imem_ready_i) begin
          state_nxt = FETCH;
          if (!stall_i) begin
            if_valid_o = 1'b1;
            pc_next_o  = pc_cur_i + XLEN'(INSTR_BYTES);
          end
        end else begin
          state_nxt = WAIT;
        end
      end

      DISCARD: begin
        if (redir) begin
          pc_next_o     = redir_target;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          misalign_o    = redir_misalign;
        end else if (imem_ready_i) begin
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic against a flag-based reference model.
module tb_pc_sequencer;

  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam int          BC   = 2;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap;
  logic [31:0] trap_vector;
  logic        imem_ready;
  logic [31:0] pc_next;
  logic        imem_req;
  logic        if_valid;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        misalign;
  logic [1:0]  state;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: cycles of boot left, request in flight, dropping a stale word
  int boot_left;
  bit waiting;
  bit discarding;

  pc_sequencer #(
    .XLEN(XLEN),
    .RESET_VECTOR(RV),
    .BOOT_CYCLES(BC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_cur_i      (pc_cur),
    .stall_i       (stall),
    .br_taken_i    (br_taken),
    .br_target_i   (br_target),
    .trap_i        (trap),
    .trap_vector_i (trap_vector),
    .imem_ready_i  (imem_ready),
    .pc_next_o     (pc_next),
    .imem_req_o    (imem_req),
    .if_valid_o    (if_valid),
    .if_id_flush_o (if_id_flush),
    .id_ex_flush_o (id_ex_flush),
    .misalign_o    (misalign),
    .state_o       (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    boot_left  = BC;
    waiting    = 1'b0;
    discarding = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"},     pc_next,     RV);
    chk({tag, "_req"},    {31'd0, imem_req},    32'd0);
    chk({tag, "_valid"},  {31'd0, if_valid},    32'd0);
    chk({tag, "_ifid"},   {31'd0, if_id_flush}, 32'd1);
    chk({tag, "_idex"},   {31'd0, id_ex_flush}, 32'd1);
    chk({tag, "_mis"},    {31'd0, misalign},    32'd0);
    chk({tag, "_state"},  {30'd0, state},       32'd0);
  endtask

  // one cycle: drive inputs, compare against the model, then clock the PC register
  task automatic step(input bit s, input bit bt, input logic [31:0] bta,
                      input bit tr, input logic [31:0] tv, input bit rdy);
    logic [31:0] e_pc, tgt, seen_pc;
    logic [1:0]  e_st;
    bit          e_req, e_val, e_fl, e_mis, redir, mis_br;
    stall = s; br_taken = bt; br_target = bta;
    trap = tr; trap_vector = tv; imem_ready = rdy;
    #4;
    redir  = tr || bt;
    mis_br = !tr && bt && (bta % 4 != 0);
    tgt    = (tr || mis_br) ? (tv / 4) * 4 : bta;
    e_pc = pc_cur; e_req = 0; e_val = 0; e_fl = 0; e_mis = 0;
    if (boot_left > 0) begin
      e_st = 2'd0; e_pc = RV; e_fl = 1;
    end else begin
      e_st  = discarding ? 2'd3 : (waiting ? 2'd2 : 2'd1);
      e_req = !discarding;
      if (redir) begin
        e_pc = tgt; e_fl = 1; e_mis = mis_br;
      end else if (rdy && !discarding && !s) begin
        e_val = 1; e_pc = pc_cur + 32'd4;
      end
    end
    chk("pc_next",  pc_next,                  e_pc);
    chk("imem_req", {31'd0, imem_req},        {31'd0, e_req});
    chk("if_valid", {31'd0, if_valid},        {31'd0, e_val});
    chk("if_id_fl", {31'd0, if_id_flush},     {31'd0, e_fl});
    chk("id_ex_fl", {31'd0, id_ex_flush},     {31'd0, e_fl});
    chk("misalign", {31'd0, misalign},        {31'd0, e_mis});
    chk("state",    {30'd0, state},           {30'd0, e_st});
    chk("flush_valid_excl", {31'd0, if_id_flush & if_valid}, 32'd0);

    if (boot_left > 0) boot_left--;
    else if (redir) begin
      discarding = discarding || waiting || !rdy;
      waiting    = 1'b0;
    end else if (rdy) begin
      discarding = 1'b0;
      waiting    = 1'b0;
    end else if (!discarding) begin
      waiting = 1'b1;
    end
    seen_pc = pc_next;
    @(posedge clk);
    pc_cur = seen_pc;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_cur = 32'h0; stall = 0; br_taken = 0; br_target = 0;
    trap = 0; trap_vector = 0; imem_ready = 0;
    #3;
    check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // boot then sequential fetch 4, 8, C, 10
    for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 0, 32'h0, 1);
    // load-use stall held three cycles at 0x10, then release
    for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0, 32'h0, 1);

    // taken branch from FETCH
    pc_cur = 32'h0000_0020;
    step(0, 1, 32'h0000_0100, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0, 32'h0, 1);

    // trap while waiting on imem, late ready dropped, then fetch at handler
    step(0, 0, 32'h0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 1, 32'h0000_0203, 0);
    step(0, 0, 32'h0, 0, 32'h0, 1);
    chk("discard_target_held", pc_cur, 32'h0000_0200);
    step(0, 0, 32'h0, 0, 32'h0, 1);

    // trap beats branch; misaligned branch reroutes; redirect beats stall
    step(0, 1, 32'h0000_0040, 1, 32'h0000_0300, 1);
    step(0, 1, 32'h0000_0042, 0, 32'h0000_0301, 1);
    step(1, 1, 32'h0000_0080, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0, 32'h0, 1);

    // PC wraps to zero
    pc_cur = 32'hFFFF_FFFC;
    step(0, 0, 32'h0, 0, 32'h0, 1);

    // asynchronous reset in the middle of WAIT
    step(0, 0, 32'h0, 0, 32'h0, 0);
    #2;
    br_taken = 1'b1; br_target = 32'h0000_0042;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    pc_cur = RV;
    model_reset();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] bta;
      bta = $urandom;
      if ($urandom_range(0, 2) != 0) bta[1:0] = 2'b00;
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), bta,
           ($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
